// File: rtl/saturn_fetch.sv
// saturn_fetch: PC owner and nibble prefetcher feeding the saturn decoder.
// Optional SATURN_FETCH_STATS_EN adds o_fetch_count (accepted nibbles).
module saturn_fetch #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [19:0] RESET_PC   = 20'h00000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en_fetch,
    output logic        o_mem_req,
    output logic [19:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [3:0]  i_mem_data,
    output logic        o_nib_valid,
    output logic [3:0]  o_nibble,
    output logic [19:0] o_pc,
    input  logic        i_consume,
    input  logic        i_jump,
    input  logic [19:0] i_jump_addr
`ifdef SATURN_FETCH_STATS_EN
    ,
    output logic [31:0] o_fetch_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t         r_state, w_state_nx;
    logic [19:0]    r_fetch_addr, r_head_pc, r_mem_addr;
    logic [19:0]    w_fetch_addr_nx, w_mem_addr_nx;
    logic [3:0]     r_fifo [FIFO_DEPTH];
    logic [AW-1:0]  r_wp, r_rp;
    logic [CW-1:0]  r_count, w_count_nx;
    logic           w_push, w_pop, w_busy;

    assign w_push      = (r_state == REQ) && i_mem_ack && !i_jump;
    assign w_pop       = i_consume && o_nib_valid && !i_jump;
    assign w_busy      = (r_state != IDLE) && !i_mem_ack;
    assign w_count_nx  = r_count + CW'(w_push) - CW'(w_pop);
    assign o_nib_valid = r_count != '0;
    assign o_nibble    = o_nib_valid ? r_fifo[r_rp] : 4'h0;
    assign o_pc        = r_head_pc;
    assign o_mem_req   = r_state != IDLE;
    assign o_mem_addr  = r_mem_addr;

    // A jump with a request still in flight must wait out that ack in DRAIN.
    always_comb begin
        w_state_nx      = r_state;
        w_mem_addr_nx   = r_mem_addr;
        w_fetch_addr_nx = r_fetch_addr;
        if (i_jump) begin
            w_fetch_addr_nx = i_jump_addr;
            w_state_nx      = w_busy ? DRAIN : REQ;
            w_mem_addr_nx   = w_busy ? r_mem_addr : i_jump_addr;
        end else if (r_state == IDLE) begin
            w_state_nx    = (r_count < FULL) ? REQ : IDLE;
            w_mem_addr_nx = (r_count < FULL) ? r_fetch_addr : r_mem_addr;
        end else if (i_mem_ack && r_state == REQ) begin
            w_fetch_addr_nx = r_fetch_addr + 20'd1;
            w_mem_addr_nx   = r_fetch_addr + 20'd1;
            w_state_nx      = (w_count_nx < FULL) ? REQ : IDLE;
        end else if (i_mem_ack) begin
            w_state_nx    = REQ;
            w_mem_addr_nx = r_fetch_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_fetch_addr <= RESET_PC;
            r_mem_addr   <= RESET_PC;
            r_head_pc    <= RESET_PC;
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
        end else if (i_en_fetch) begin
            r_state      <= w_state_nx;
            r_fetch_addr <= w_fetch_addr_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_count      <= i_jump ? '0 : w_count_nx;
            r_wp         <= i_jump ? '0 : r_wp + AW'(w_push);
            r_rp         <= i_jump ? '0 : r_rp + AW'(w_pop);
            r_head_pc    <= i_jump ? i_jump_addr : r_head_pc + 20'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset && i_en_fetch && w_push) r_fifo[r_wp] <= i_mem_data;
    end

`ifdef SATURN_FETCH_STATS_EN
    logic [31:0] r_fetch_count;
    assign o_fetch_count = r_fetch_count;
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_fetch_count <= '0;
        else if (i_en_fetch && w_push) r_fetch_count <= r_fetch_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_saturn_fetch.sv
// tb_saturn_fetch: randomized scoreboard bench; memory content is a fixed function of address.
module tb_saturn_fetch;
    localparam int          DEPTH = 4;
    localparam logic [19:0] RPC   = 20'h00000;

    logic        clk = 0, rst_n = 0, en = 0, ack = 0, consume = 0, jump = 0;
    logic [3:0]  mdata = 0;
    logic [19:0] jaddr = 0;
    logic        o_mem_req, o_nib_valid;
    logic [19:0] o_mem_addr, o_pc;
    logic [3:0]  o_nibble;
`ifdef SATURN_FETCH_STATS_EN
    logic [31:0] o_fetch_count;
`endif

    saturn_fetch #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_en_fetch(en),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(ack), .i_mem_data(mdata),
        .o_nib_valid(o_nib_valid), .o_nibble(o_nibble), .o_pc(o_pc),
        .i_consume(consume), .i_jump(jump), .i_jump_addr(jaddr)
`ifdef SATURN_FETCH_STATS_EN
        , .o_fetch_count(o_fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [23:0] q[$];

    function automatic logic [3:0] memf(input logic [19:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ a[19:16] ^ 4'h9;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: occupancy, next fetch address, and whether the in-flight ack is stale.
    int          occ = 0, p_occ = 0, fetched = 0;
    logic [19:0] fa = RPC, p_addr = RPC;
    logic        stale = 0, known = 0;
    logic        p_rst = 1, p_en = 0, p_req = 0, p_ack = 0, p_jump = 0;

    always @(negedge clk) begin
        logic pop, acc;
        logic [23:0] e;
        if (known && !p_rst) begin
            chk("rst_req", 32'(o_mem_req), 32'd0);
            chk("rst_valid", 32'(o_nib_valid), 32'd0);
            chk("rst_pc", 32'(o_pc), 32'(RPC));
            chk("rst_addr", 32'(o_mem_addr), 32'(RPC));
            chk("rst_nibble", 32'(o_nibble), 32'd0);
        end else if (known) begin
            chk("valid", 32'(o_nib_valid), 32'(occ != 0));
            if (occ == DEPTH) chk("full_no_req", 32'(o_mem_req), 32'd0);
            if (p_en && !p_req) begin
                chk("req_start", 32'(o_mem_req), 32'(p_jump || p_occ < DEPTH));
                if (o_mem_req) chk("req_start_addr", 32'(o_mem_addr), 32'(fa));
            end
            if (p_req && (!p_en || !p_ack)) begin
                chk("req_hold", 32'(o_mem_req), 32'd1);
                chk("addr_hold", 32'(o_mem_addr), 32'(p_addr));
            end
            if (!p_en && !p_req) chk("idle_hold", 32'(o_mem_req), 32'd0);
`ifdef SATURN_FETCH_STATS_EN
            chk("fetch_count", o_fetch_count, 32'(fetched));
`endif
        end
        p_rst = rst_n; p_en = en; p_req = o_mem_req; p_ack = ack;
        p_jump = jump; p_addr = o_mem_addr; p_occ = occ;
        if (!rst_n) begin
            known = 1; occ = 0; fa = RPC; stale = 0; fetched = 0;
            q.delete();
        end else if (en && known) begin
            pop = consume && o_nib_valid && !jump;
            acc = o_mem_req && ack && !jump && !stale;
            if (pop) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL pop_unexpected actual=%h/%h required=none", o_pc, o_nibble);
                end else begin
                    e = q.pop_front();
                    chk("pop_pc", 32'(o_pc), 32'(e[23:4]));
                    chk("pop_nibble", 32'(o_nibble), 32'(e[3:0]));
                end
            end
            if (acc) begin
                chk("ack_addr", 32'(o_mem_addr), 32'(fa));
                fa = fa + 20'd1;
                fetched++;
            end
            if (jump) begin
                stale = o_mem_req && !ack;
                fa = jaddr;
                occ = 0;
            end else begin
                if (o_mem_req && ack) stale = 0;
                occ = occ + int'(acc) - int'(pop);
            end
        end
    end

    logic [19:0] spc = RPC;

    initial begin
        rst_n = 0; en = 1;
        repeat (3) @(posedge clk);
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst_n   = !(c >= 2000 && c < 2002);
            en      = (c < 20) || ($urandom_range(9) != 0);
            jump    = (c >= 20) && ($urandom_range(19) == 0);
            jaddr   = $urandom_range(1) ? 20'hFFFFE - 20'($urandom_range(2)) : 20'($urandom);
            consume = (c % 200 < 40) ? 1'b0 : ($urandom_range(9) < 6);
            ack     = o_mem_req && ($urandom_range(9) < 7);
            mdata   = ack ? memf(o_mem_addr) : 4'($urandom);
            if (!rst_n) spc = RPC;
            else if (en) begin
                if (jump) spc = jaddr;
                else if (consume && o_nib_valid) begin
                    q.push_back({spc, memf(spc)});
                    spc = spc + 20'd1;
                end
            end
        end
        @(posedge clk); #1;
        consume = 0; jump = 0; ack = 0;
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
